// File: rtl/cpu_core_p.sv
// Parametrised teaching CPU: MOV/ACC/JMP/ATC plus CALL/RET on a hardware return stack and HALT.
// One instruction retires per cycle with step_i in RUN. Button events land in the flag register every clock.
module cpu_core_p #(
  parameter  int DATA_W      = 8,
  parameter  int ADDR_W      = 8,
  parameter  int STACK_DEPTH = 4,
  localparam int IW          = 11 + 2*DATA_W + ADDR_W,
  localparam int SPW         = $clog2(STACK_DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_i,
  input  logic [IW-1:0]     instr_i,
  input  logic [3:0]        btn_evt_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [ADDR_W-1:0] ip_o,
  output logic [DATA_W-1:0] dout_o,
  output logic [5:0]        gpo_o,
  output logic              dval_o,
  output logic [7:0]        flags_o,
  output logic [SPW-1:0]    sp_o,
  output logic              halted_o,
  output logic              fault_o
);
  localparam int DW2 = 2*DATA_W;

  typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ip_q, ip_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic [DATA_W-1:0] regs_q  [32];
  logic [DATA_W-1:0] regs_d  [32];

  logic [3:0]        grp;
  logic [2:0]        cmd;
  logic [1:0]        t1, t2;
  logic [DATA_W-1:0] a1, a2;
  logic [ADDR_W-1:0] addr;
  assign {grp, cmd, t1, a1, t2, a2, addr} = instr_i;

  // Operand decode: type 0 is an immediate whose location is R0.
  logic [4:0]        ind1, ind2, loc1, loc2;
  logic [DATA_W-1:0] num1, num2, acc;
  assign ind1 = regs_q[a1[4:0]][4:0];
  assign ind2 = regs_q[a2[4:0]][4:0];

  always_comb begin
    loc1 = 5'd0;
    loc2 = 5'd0;
    num1 = a1;
    num2 = a2;
    case (t1)
      2'd1:    begin loc1 = a1[4:0]; num1 = regs_q[a1[4:0]]; end
      2'd2:    begin loc1 = ind1;    num1 = regs_q[ind1];    end
      default: ;
    endcase
    case (t2)
      2'd1:    begin loc2 = a2[4:0]; num2 = regs_q[a2[4:0]]; end
      2'd2:    begin loc2 = ind2;    num2 = regs_q[ind2];    end
      default: ;
    endcase
  end

  assign acc = regs_q[loc1];

  // Arithmetic at double width so overflow is read straight off the upper half.
  logic [DW2-1:0] acc_u, src_u, acc_s, src_s, r_uad, r_sad, r_umt, r_smt;
  assign acc_u = {{DATA_W{1'b0}}, acc};
  assign src_u = {{DATA_W{1'b0}}, num2};
  assign acc_s = {{DATA_W{acc[DATA_W-1]}}, acc};
  assign src_s = {{DATA_W{num2[DATA_W-1]}}, num2};
  assign r_uad = acc_u + src_u;
  assign r_sad = acc_s + src_s;
  assign r_umt = acc_u * src_u;
  assign r_smt = $signed(acc_s) * $signed(src_s);

  function automatic logic s_ovf(input logic [DW2-1:0] v);
    return !((&v[DW2-1:DATA_W-1]) || !(|v[DW2-1:DATA_W-1]));
  endfunction

  logic              wr_en, ovf_en, ovf, shf_en, shf, stk_err, jmp_take;
  logic [4:0]        wr_idx;
  logic [DATA_W-1:0] wr_val;

  always_comb begin
    state_d  = state_q;
    ip_d     = ip_q;
    sp_d     = sp_q;
    stack_d  = stack_q;
    regs_d   = regs_q;
    wr_en    = 1'b0;
    wr_idx   = 5'd0;
    wr_val   = '0;
    ovf_en   = 1'b0;
    ovf      = 1'b0;
    shf_en   = 1'b0;
    shf      = 1'b0;
    stk_err  = 1'b0;
    jmp_take = 1'b0;

    if (step_i && state_q == S_RUN) begin
      ip_d = ip_q + 1'b1;
      case (grp)
        4'd0: begin
          wr_idx = loc2;
          case (cmd)
            3'd0: begin wr_en = 1'b1; wr_val = num1; end
            3'd1: begin wr_en = 1'b1; wr_val = {num1[DATA_W-2:0], 1'b0};
                        shf_en = 1'b1; shf = num1[DATA_W-1]; end
            3'd2: begin wr_en = 1'b1; wr_val = {1'b0, num1[DATA_W-1:1]};
                        shf_en = 1'b1; shf = num1[0]; end
            default: ;
          endcase
        end
        4'd1: begin
          wr_idx = loc1;
          wr_en  = 1'b1;
          case (cmd)
            3'd0: begin wr_val = r_uad[DATA_W-1:0]; ovf_en = 1'b1; ovf = |r_uad[DW2-1:DATA_W]; end
            3'd1: begin wr_val = r_sad[DATA_W-1:0]; ovf_en = 1'b1; ovf = s_ovf(r_sad); end
            3'd2: begin wr_val = r_umt[DATA_W-1:0]; ovf_en = 1'b1; ovf = |r_umt[DW2-1:DATA_W]; end
            3'd3: begin wr_val = r_smt[DATA_W-1:0]; ovf_en = 1'b1; ovf = s_ovf(r_smt); end
            3'd4: wr_val = acc & num2;
            3'd5: wr_val = acc | num2;
            3'd6: wr_val = acc ^ num2;
            default: wr_en = 1'b0;
          endcase
        end
        4'd2: begin
          case (cmd)
            3'd0: jmp_take = 1'b1;
            3'd1: jmp_take = (num1 == num2);
            3'd2: jmp_take = (num1 <  num2);
            3'd3: jmp_take = ($signed(num1) <  $signed(num2));
            3'd4: jmp_take = (num1 <= num2);
            3'd5: jmp_take = ($signed(num1) <= $signed(num2));
            default: ;
          endcase
          if (jmp_take) ip_d = addr;
        end
        4'd3: begin
          if (regs_q[31][cmd]) ip_d = addr;
        end
        4'd4: begin
          if (sp_q == SPW'(STACK_DEPTH)) begin
            stk_err = 1'b1;
            ip_d    = ip_q;
            state_d = S_FAULT;
          end else begin
            for (int k = 0; k < STACK_DEPTH; k++)
              if (sp_q == SPW'(k)) stack_d[k] = ip_q + 1'b1;
            sp_d = sp_q + 1'b1;
            ip_d = addr;
          end
        end
        4'd5: begin
          if (sp_q == '0) begin
            stk_err = 1'b1;
            ip_d    = ip_q;
            state_d = S_FAULT;
          end else begin
            for (int k = 0; k < STACK_DEPTH; k++)
              if (sp_q == SPW'(k+1)) ip_d = stack_q[k];
            sp_d = sp_q - 1'b1;
          end
        end
        4'd6: begin
          ip_d    = ip_q;
          state_d = S_HALT;
        end
        default: ;
      endcase

      if (wr_en)   regs_d[wr_idx] = wr_val;
      if (shf_en)  regs_d[31][4] = shf;
      if (ovf_en)  regs_d[31][5] = ovf;
      if (stk_err) regs_d[31][6] = 1'b1;
      if (grp == 4'd3) regs_d[31][cmd] = 1'b0;
    end

    // Events are applied last so they beat any instruction clear/write this cycle.
    for (int j = 0; j < 4; j++)
      if (btn_evt_i[j]) regs_d[31][j] = 1'b1;
    if (btn_evt_i[3]) regs_d[28] = din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      ip_q    <= '0;
      sp_q    <= '0;
      for (int k = 0; k < STACK_DEPTH; k++) stack_q[k] <= '0;
      for (int r = 0; r < 32; r++)          regs_q[r]  <= '0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      sp_q    <= sp_d;
      stack_q <= stack_d;
      regs_q  <= regs_d;
    end
  end

  assign ip_o     = ip_q;
  assign sp_o     = sp_q;
  assign dout_o   = regs_q[30];
  assign gpo_o    = regs_q[29][5:0];
  assign dval_o   = regs_q[29][7];
  assign flags_o  = regs_q[31][7:0];
  assign halted_o = (state_q == S_HALT);
  assign fault_o  = (state_q == S_FAULT);
endmodule

// File: tb/tb_cpu_core_p.sv
// Directed bench for cpu_core_p (DATA_W=8, ADDR_W=8, STACK_DEPTH=2); instructions are driven
// straight onto instr_i one step at a time with hand-computed expectations.
module tb_cpu_core_p;
  localparam int IW = 35;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_i = 1'b0;
  logic [IW-1:0] instr_i = '0;
  logic [3:0]    btn_evt_i = 4'h0;
  logic [7:0]    din_i = 8'h00;
  logic [7:0]    ip_o, dout_o, flags_o;
  logic [5:0]    gpo_o;
  logic          dval_o, halted_o, fault_o;
  logic [1:0]    sp_o;

  int checks = 0;
  int errors = 0;

  cpu_core_p #(.DATA_W(8), .ADDR_W(8), .STACK_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .step_i(step_i), .instr_i(instr_i),
    .btn_evt_i(btn_evt_i), .din_i(din_i), .ip_o(ip_o), .dout_o(dout_o),
    .gpo_o(gpo_o), .dval_o(dval_o), .flags_o(flags_o), .sp_o(sp_o),
    .halted_o(halted_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk(input logic [3:0] g, input logic [2:0] c,
                                       input logic [1:0] ta, input logic [7:0] aa,
                                       input logic [1:0] tb, input logic [7:0] ab,
                                       input logic [7:0] ad);
    return {g, c, ta, aa, tb, ab, ad};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that executed the step.
  task automatic exec(input logic [IW-1:0] ins, input logic [3:0] btn = 4'h0);
    instr_i   = ins;
    step_i    = 1'b1;
    btn_evt_i = btn;
    @(posedge clk); #1;
    step_i    = 1'b0;
    btn_evt_i = 4'h0;
  endtask

  task automatic pulse(input logic [3:0] btn, input logic [7:0] d);
    btn_evt_i = btn;
    din_i     = d;
    @(posedge clk); #1;
    btn_evt_i = 4'h0;
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ip", ip_o, 0);
    chk("rst_sp", sp_o, 0);
    chk("rst_fault", fault_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ip", ip_o, 0);
    chk("reset_dout", dout_o, 0);
    chk("reset_flags", flags_o, 0);
    chk("reset_sp", sp_o, 0);
    chk("reset_state", {halted_o, fault_o, dval_o, gpo_o}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    exec(mk(0, 0, 0, 8'hA5, 1, 30, 0));
    chk("mov_dout", dout_o, 8'hA5);
    chk("mov_ip", ip_o, 1);

    exec(mk(0, 0, 0, 8'd200, 1, 1, 0));
    exec(mk(1, 0, 1, 1, 0, 8'd100, 0));
    chk("uad_oflw", flags_o, 8'h20);
    exec(mk(0, 0, 1, 1, 1, 30, 0));
    chk("uad_res", dout_o, 8'd44);

    exec(mk(0, 0, 0, 8'h7F, 1, 1, 0));
    exec(mk(1, 0, 1, 2, 0, 1, 0));
    chk("uad_no_oflw", flags_o[5], 0);
    exec(mk(1, 1, 1, 1, 0, 1, 0));
    chk("sad_oflw", flags_o[5], 1);
    exec(mk(0, 0, 0, 1, 1, 5, 0));
    exec(mk(0, 0, 2, 5, 1, 30, 0));
    chk("sad_res_ind", dout_o, 8'h80);

    exec(mk(0, 1, 0, 8'h81, 1, 30, 0));
    chk("shl_res", dout_o, 8'h02);
    chk("shl_flags", flags_o, 8'h30);

    exec(mk(2, 0, 0, 0, 0, 0, 8'h03));
    chk("jmp_unc", ip_o, 3);
    exec(mk(4, 0, 0, 0, 0, 0, 8'h10));
    chk("call_ip", ip_o, 8'h10);
    chk("call_sp", sp_o, 1);
    exec(mk(5, 0, 0, 0, 0, 0, 0));
    chk("ret_ip", ip_o, 4);
    chk("ret_sp", sp_o, 0);

    exec(mk(2, 3, 1, 1, 0, 0, 8'h40));
    chk("jmp_slt", ip_o, 8'h40);
    exec(mk(2, 2, 1, 1, 0, 0, 8'h99));
    chk("jmp_ult_not", ip_o, 8'h41);
    exec(mk(2, 1, 1, 1, 0, 8'h80, 8'h44));
    chk("jmp_eq", ip_o, 8'h44);

    pulse(4'b0001, 8'h00);
    chk("btn_set", flags_o, 8'h31);
    exec(mk(3, 0, 0, 0, 0, 0, 8'h20));
    chk("atc_ip", ip_o, 8'h20);
    chk("atc_clr", flags_o, 8'h30);
    exec(mk(3, 0, 0, 0, 0, 0, 8'h20));
    chk("atc_not_taken", ip_o, 8'h21);
    pulse(4'b0001, 8'h00);
    exec(mk(3, 0, 0, 0, 0, 0, 8'h50), 4'b0001);
    chk("atc_race_ip", ip_o, 8'h50);
    chk("atc_race_bit", flags_o[0], 1);

    pulse(4'b1000, 8'h3C);
    chk("sample_flag", flags_o, 8'h39);
    exec(mk(0, 0, 1, 28, 1, 30, 0));
    chk("sample_din", dout_o, 8'h3C);

    exec(mk(4, 0, 0, 0, 0, 0, 8'h60));
    exec(mk(4, 0, 0, 0, 0, 0, 8'h70));
    chk("call2_sp", sp_o, 2);
    exec(mk(4, 0, 0, 0, 0, 0, 8'h80));
    chk("ovf_sp", sp_o, 2);
    chk("ovf_fault", fault_o, 1);
    chk("ovf_stk", flags_o[6], 1);
    chk("ovf_ip", ip_o, 8'h70);
    exec(mk(0, 0, 0, 8'h55, 1, 30, 0));
    chk("fault_frozen", {ip_o, dout_o}, {8'h70, 8'h3C});
    reset_pulse();

    exec(mk(5, 0, 0, 0, 0, 0, 0));
    chk("ret_empty_fault", {fault_o, flags_o[6]}, 2'b11);
    chk("ret_empty_ip", ip_o, 0);
    reset_pulse();

    exec(mk(2, 0, 0, 0, 0, 0, 8'hFF));
    chk("jmp_ff", ip_o, 8'hFF);
    exec(mk(7, 0, 0, 0, 0, 0, 0));
    chk("ip_wrap", ip_o, 0);

    exec(mk(0, 0, 0, 8'h11, 1, 30, 0));
    exec(mk(6, 0, 0, 0, 0, 0, 0));
    chk("halt_flag", halted_o, 1);
    chk("halt_ip", ip_o, 1);
    exec(mk(0, 0, 0, 8'h22, 1, 30, 0));
    chk("halt_frozen", {ip_o, dout_o}, {8'h01, 8'h11});

    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", {ip_o, dout_o, halted_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
